// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared sizing defaults for the FIFO memory and its
//                read/write controllers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;
    parameter int ADDR_WIDTH = 4;
    parameter int DATA_WIDTH = 8;
endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_ctrl_if
//  Description : First-word-fall-through valid/ready stream carrying FIFO
//                entries from the read controller to its consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_rd_ctrl_if #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    // Producer side: the read controller
    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    // Consumer side
    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface : fifo_rd_ctrl_if
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_ctrl
//  Description : Read-side controller of the single-clock FIFO. Issues memory
//                reads while entries remain, absorbs the one-cycle registered
//                read latency in a 2-entry skid buffer and presents entries
//                in order on a first-word-fall-through valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl #(
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    fifo_rd_ctrl_if.master        m_if,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  empty,
    output logic                  ptr_err
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] c_DEPTH = PTR_W'(1) << ADDR_WIDTH;

    // Registered state
    logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            occ_q,      occ_d;
    logic [DATA_WIDTH-1:0] head_q,     head_d;
    logic [DATA_WIDTH-1:0] tail_q,     tail_d;
    logic                  ptr_err_q,  ptr_err_d;

    // Decode
    logic [PTR_W-1:0] w_ptr_diff;
    logic             w_mem_empty;
    logic             w_valid;
    logic             w_pop;
    logic [2:0]       w_pending;
    logic             w_fetch;

    assign w_ptr_diff  = wr_ptr - rd_ptr_q;
    assign w_mem_empty = (wr_ptr == rd_ptr_q);
    assign w_valid     = (occ_q != 2'd0);
    assign w_pop       = w_valid && m_if.m_ready;

    // Entries the buffer will hold once this cycle's capture and pop settle;
    // a new fetch is allowed only if its data will still find a free slot.
    assign w_pending   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    assign w_fetch     = !w_mem_empty && (w_pending < 3'd2);

    // Next-state: pointer advance, in-flight tracking and skid-buffer update
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        inflight_d = w_fetch;
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        ptr_err_d  = ptr_err_q | (w_ptr_diff > c_DEPTH);

        if (w_fetch) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({w_pop, inflight_q})
            2'b10: begin
                // Pop only: second entry (if any) moves up to head
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b01: begin
                // Capture only: append behind the existing entries
                if (occ_q == 2'd0) begin
                    head_d = mem_rd_data;
                end else begin
                    tail_d = mem_rd_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                // Pop and capture together: occupancy unchanged, order kept
                if (occ_q == 2'd1) begin
                    head_d = mem_rd_data;
                end else begin
                    head_d = tail_q;
                    tail_d = mem_rd_data;
                end
            end
            default: begin
            end
        endcase
    end

    // State registers with synchronous reset discarding buffered/in-flight data
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            ptr_err_q  <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            ptr_err_q  <= ptr_err_d;
        end
    end

    // Outputs
    assign rd_ptr       = rd_ptr_q;
    assign mem_rd_addr  = rd_ptr_q[ADDR_WIDTH-1:0];
    assign m_if.m_valid = w_valid;
    assign m_if.m_data  = head_q;
    assign empty        = !w_valid;
    assign ptr_err      = ptr_err_q;
    // Entries still in memory, plus one being fetched, plus those buffered
    assign level        = w_ptr_diff + PTR_W'(inflight_q) + PTR_W'(occ_q);

endmodule : fifo_rd_ctrl
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_ctrl
//  Description : Directed self-checking bench for fifo_rd_ctrl with a
//                registered-read memory model (ADDR_WIDTH=4, DATA_WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int PW = AW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [PW-1:0] level;
    logic          empty;
    logic          ptr_err;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_pass   = 0;
    int exp_addr [6] = '{14, 15, 0, 1, 2, 3};

    fifo_rd_ctrl_if #(.DATA_WIDTH(DW)) u_if ();

    fifo_rd_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) u_dut (
        .rd_clk      (clk),
        .rd_rst      (rst),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .m_if        (u_if),
        .level       (level),
        .empty       (empty),
        .ptr_err     (ptr_err)
    );

    always #5 clk = ~clk;

    // Memory with one-cycle registered read
    always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge (start of next cycle)
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        wr_ptr       = '0;
        u_if.m_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

        // ---------------- Reset ----------------
        do_reset();
        @(negedge clk);
        chk("rst_valid", 32'(u_if.m_valid), 32'd0);
        chk("rst_data",  32'(u_if.m_data),  32'd0);
        chk("rst_empty", 32'(empty),        32'd1);
        chk("rst_level", 32'(level),        32'd0);
        chk("rst_rdptr", 32'(rd_ptr),       32'd0);
        chk("rst_addr",  32'(mem_rd_addr),  32'd0);
        chk("rst_err",   32'(ptr_err),      32'd0);

        // ---------------- Single entry ----------------
        step();
        mem[0] = 8'hA5;
        wr_ptr = 5'd1;                       // cycle 0
        @(negedge clk);
        chk("single_addr_c0",  32'(mem_rd_addr), 32'd0);
        chk("single_level_c0", 32'(level),       32'd1);
        step();                              // cycle 1
        @(negedge clk);
        chk("single_valid_c1", 32'(u_if.m_valid), 32'd0);
        chk("single_rdptr_c1", 32'(rd_ptr),      32'd1);
        chk("single_level_c1", 32'(level),       32'd1);
        step();                              // cycle 2
        @(negedge clk);
        chk("single_valid_c2", 32'(u_if.m_valid), 32'd1);
        chk("single_data_c2",  32'(u_if.m_data),  32'hA5);
        chk("single_empty_c2", 32'(empty),        32'd0);
        step();
        u_if.m_ready = 1'b1;                 // pop in cycle 3
        @(negedge clk);
        chk("single_data_c3", 32'(u_if.m_data), 32'hA5);
        step();
        u_if.m_ready = 1'b0;
        @(negedge clk);
        chk("single_empty_after", 32'(empty), 32'd1);
        chk("single_level_after", 32'(level), 32'd0);

        // ---------------- Streaming ----------------
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        wr_ptr       = 5'd16;
        u_if.m_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            chk("stream_valid", 32'(u_if.m_valid), (cyc >= 2 && cyc <= 17) ? 32'd1 : 32'd0);
            if (cyc >= 2 && cyc <= 17) chk("stream_data", 32'(u_if.m_data), 32'(cyc - 2));
            step();
        end
        @(negedge clk);
        chk("stream_rdptr_end", 32'(rd_ptr),  32'd16);
        chk("stream_level_end", 32'(level),   32'd0);
        chk("stream_err",       32'(ptr_err), 32'd0);

        // ---------------- Backpressure ----------------
        do_reset();
        for (int i = 0; i < 5; i++) mem[i] = 8'(8'h50 + i);
        wr_ptr = 5'd5;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            chk("bp_level", 32'(level), 32'd5);
            if (cyc >= 3) begin
                chk("bp_valid", 32'(u_if.m_valid), 32'd1);
                chk("bp_data",  32'(u_if.m_data),  32'h50);
                chk("bp_rdptr", 32'(rd_ptr),       32'd2);
            end
            step();
        end
        u_if.m_ready = 1'b1;                 // cycle 6
        for (int cyc = 6; cyc < 12; cyc++) begin
            @(negedge clk);
            chk("bp_drain_valid", 32'(u_if.m_valid), (cyc <= 10) ? 32'd1 : 32'd0);
            if (cyc <= 10) chk("bp_drain_data", 32'(u_if.m_data), 32'(8'h50 + cyc - 6));
            step();
        end
        @(negedge clk);
        chk("bp_level_end", 32'(level), 32'd0);

        // ---------------- Wrap-around ----------------
        do_reset();
        wr_ptr       = 5'd14;
        u_if.m_ready = 1'b1;
        repeat (20) step();
        @(negedge clk);
        chk("wrap_rdptr_start", 32'(rd_ptr), 32'd14);
        chk("wrap_level_start", 32'(level),  32'd0);
        step();
        mem[14] = 8'hC0;
        mem[15] = 8'hC1;
        for (int i = 0; i < 4; i++) mem[i] = 8'(8'hC2 + i);
        wr_ptr = 5'd20;                      // cycle 0
        for (int cyc = 0; cyc < 9; cyc++) begin
            @(negedge clk);
            if (cyc < 6) chk("wrap_addr", 32'(mem_rd_addr), 32'(exp_addr[cyc]));
            chk("wrap_valid", 32'(u_if.m_valid), (cyc >= 2 && cyc <= 7) ? 32'd1 : 32'd0);
            if (cyc >= 2 && cyc <= 7) chk("wrap_data", 32'(u_if.m_data), 32'(8'hC0 + cyc - 2));
            step();
        end
        @(negedge clk);
        chk("wrap_rdptr_end", 32'(rd_ptr), 32'd20);

        // ---------------- Reset mid-flight and pointer error ----------------
        do_reset();
        for (int i = 0; i < 5; i++) mem[i] = 8'(8'h30 + i);
        wr_ptr = 5'd5;
        repeat (4) step();
        @(negedge clk);
        chk("mid_pre_valid", 32'(u_if.m_valid), 32'd1);
        chk("mid_pre_rdptr", 32'(rd_ptr),      32'd2);
        step();
        rst    = 1'b1;
        wr_ptr = '0;
        step();
        @(negedge clk);
        chk("mid_valid", 32'(u_if.m_valid), 32'd0);
        chk("mid_rdptr", 32'(rd_ptr),       32'd0);
        chk("mid_empty", 32'(empty),        32'd1);
        step();
        rst    = 1'b0;
        wr_ptr = 5'd17;
        @(negedge clk);
        chk("err_before", 32'(ptr_err), 32'd0);
        chk("err_level",  32'(level),   32'd17);
        step();
        @(negedge clk);
        chk("err_set", 32'(ptr_err), 32'd1);
        step();
        @(negedge clk);
        chk("err_sticky", 32'(ptr_err), 32'd1);
        step();
        rst    = 1'b1;
        wr_ptr = '0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(ptr_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fifo_rd_ctrl
`default_nettype wire
